// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: data width, transmitter FSM encoding and the bit-period helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

  // Also intended for the matching receiver so both ends agree on the bit period.
  function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with full/empty derived from a registered occupancy count.
module uart_byte_fifo #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (ADDR_WIDTH + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) fed by a byte FIFO.
// Holds the baud counter, bit index, shift register and framing FSM.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overflow,
  output logic                   o_busy,
  output logic                   o_tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_W - 1);

  tx_state_e              r_state, w_state_d;
  logic [CNT_W-1:0]       r_baud_cnt, w_baud_cnt_d;
  logic [2:0]             r_bit_idx, w_bit_idx_d;
  logic [UART_DATA_W-1:0] r_shift, w_shift_d;
  logic                   r_tx, w_tx_d;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_bit_end;
  logic [UART_DATA_W-1:0] w_rdata;
  logic                   w_full;
  logic                   w_empty;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_parity_d;
`endif

  uart_byte_fifo #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .DATA_W     (UART_DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_en),
    .i_wdata (i_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  // w_tx_d is the line level for the state being entered, so o_tx stays a plain flop.
  always_comb begin
    w_state_d    = r_state;
    w_baud_cnt_d = r_baud_cnt + CNT_W'(1);
    w_bit_idx_d  = r_bit_idx;
    w_shift_d    = r_shift;
    w_tx_d       = r_tx;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_d   = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        w_baud_cnt_d = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_rdata;
          w_state_d = StStart;
          w_tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_d = ^w_rdata;
`endif
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d    = StData;
          w_baud_cnt_d = '0;
          w_bit_idx_d  = '0;
          w_tx_d       = r_shift[0];
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_cnt_d = '0;
          if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
            w_tx_d    = r_parity;
`else
            w_state_d = StStop;
            w_tx_d    = 1'b1;
`endif
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
            w_shift_d   = {1'b0, r_shift[UART_DATA_W-1:1]};
            w_tx_d      = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_bit_end) begin
          w_state_d    = StStop;
          w_baud_cnt_d = '0;
          w_tx_d       = 1'b1;
        end
      end
`endif
      StStop: begin
        if (w_bit_end) begin
          w_baud_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_rdata;
            w_state_d = StStart;
            w_tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_parity_d = ^w_rdata;
`endif
          end else begin
            w_state_d = StIdle;
            w_tx_d    = 1'b1;
          end
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_baud_cnt_d = '0;
        w_tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      if (i_wr_en && w_full) r_overflow <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_d;
`endif
    end
  end

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != StIdle);
  assign o_tx       = r_tx;

endmodule
